// File: rtl/mu0_mem_responder_if.sv
// rtl/mu0_mem_responder_if.sv - MU0 memory bus: request from the CPU side, acknowledge from memory
interface mu0_mem_responder_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WrData;
    logic              Rd;
    logic              Wr;
    logic [DATA_W-1:0] RdData;
    logic              Ack;
    logic              Err;
    logic              Busy;

    modport master (
        output Addr, WrData, Rd, Wr,
        input  RdData, Ack, Err, Busy
    );

    modport slave (
        input  Addr, WrData, Rd, Wr,
        output RdData, Ack, Err, Busy
    );
endinterface

// File: rtl/mu0_mem_responder.sv
// rtl/mu0_mem_responder.sv - word store with programmable wait states and single-cycle acknowledge
module mu0_mem_responder #(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    mu0_mem_responder_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_BAD} op_e;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    state_e            state_q;
    op_e               op_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              access_go;
    logic              mem_we;

    assign access_go = (state_q == S_WAIT) && (cnt_q == 4'd0);
    // Gating with Reset keeps an aborted write from reaching the store.
    assign mem_we    = !Reset && access_go && (op_q == OP_WRITE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_READ;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.Rd || bus.Wr) begin
                        addr_q  <= bus.Addr;
                        wdata_q <= bus.WrData;
                        op_q    <= (bus.Rd && bus.Wr) ? OP_BAD :
                                   (bus.Rd ? OP_READ : OP_WRITE);
                        cnt_q   <= WAIT_CNT;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                        if (op_q == OP_READ) begin
                            rdata_q <= mem[addr_q];
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The store has no reset so it maps onto plain RAM.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bus.RdData = rdata_q;
    assign bus.Ack    = (state_q == S_RESP);
    assign bus.Err    = (state_q == S_RESP) && (op_q == OP_BAD);
    assign bus.Busy   = (state_q != S_IDLE);
endmodule

// File: tb/tb_mu0_mem_responder.sv
// tb/tb_mu0_mem_responder.sv - randomized model-checked bench for mu0_mem_responder
module tb_mu0_mem_responder;
    localparam int WS = 2;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    mu0_mem_responder_if #(.ADDR_W(12), .DATA_W(16)) bus  ();
    mu0_mem_responder_if #(.ADDR_W(12), .DATA_W(16)) bus0 ();

    mu0_mem_responder #(.WAIT_STATES(WS), .ADDR_W(12), .DATA_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus.slave)
    );
    mu0_mem_responder #(.WAIT_STATES(0), .ADDR_W(12), .DATA_W(16)) dut0 (
        .Clk(Clk), .Reset(Reset), .bus(bus0.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model for the WAIT_STATES=2 instance
    logic [15:0] ref_mem   [4096];
    bit          ref_valid [4096];
    logic [15:0] last_rd;

    // Called at a negedge; returns at the negedge after the Ack cycle.
    // lat = clock edges from the accept edge to the edge that raises Ack.
    task automatic access(input bit sel, input bit rd, input bit wr,
                          input logic [11:0] a, input logic [15:0] d,
                          output int lat, output bit err, output logic [15:0] rdat,
                          output bit busy1, output bit ack_after);
        bit ack;
        lat = -1; err = 1'b0; rdat = 16'h0; ack_after = 1'b1;
        if (sel) begin
            bus0.Rd = rd; bus0.Wr = wr; bus0.Addr = a; bus0.WrData = d;
        end else begin
            bus.Rd = rd; bus.Wr = wr; bus.Addr = a; bus.WrData = d;
        end
        @(negedge Clk);
        busy1 = sel ? bus0.Busy : bus.Busy;
        bus.Rd = 1'b0; bus.Wr = 1'b0; bus0.Rd = 1'b0; bus0.Wr = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            ack = sel ? bus0.Ack : bus.Ack;
            if (ack) begin
                lat  = n - 1;
                err  = sel ? bus0.Err : bus.Err;
                rdat = sel ? bus0.RdData : bus.RdData;
                @(negedge Clk);
                ack_after = sel ? bus0.Ack : bus.Ack;
                break;
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.Rd = 1'b1; bus.Wr = 1'b0; bus.Addr = 12'h055; bus.WrData = 16'h0;
        bus0.Rd = 1'b1; bus0.Wr = 1'b0; bus0.Addr = 12'h055; bus0.WrData = 16'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            if (c == 2) begin
                Reset = 1'b0; bus.Rd = 1'b0; bus0.Rd = 1'b0;
            end
            checks++;
            if ({bus.Busy, bus.Ack, bus.Err, bus.RdData} !== 19'h0) begin
                errors++;
                $display("FAIL reset_state c=%0d: busy=%b ack=%b err=%b rd=%h, want all 0",
                         c, bus.Busy, bus.Ack, bus.Err, bus.RdData);
            end
            checks++;
            if ({bus0.Busy, bus0.Ack, bus0.Err, bus0.RdData} !== 19'h0) begin
                errors++;
                $display("FAIL reset_state_ws0 c=%0d: busy=%b ack=%b err=%b rd=%h, want all 0",
                         c, bus0.Busy, bus0.Ack, bus0.Err, bus0.RdData);
            end
        end
        @(negedge Clk);
        checks++;
        if ({bus.Busy, bus.Ack, bus.RdData} !== 18'h0) begin
            errors++;
            $display("FAIL after_reset: busy=%b ack=%b rd=%h, want 0", bus.Busy, bus.Ack, bus.RdData);
        end
        last_rd = 16'h0;
    endtask

    // Model-side bookkeeping after a WAIT_STATES=2 access, with its checks
    task automatic model_access(input string name, input bit rd, input bit wr,
                                input logic [11:0] a, input logic [15:0] d);
        int lat; bit err, busy1, ack_after; logic [15:0] rdat, exp;
        access(1'b0, rd, wr, a, d, lat, err, rdat, busy1, ack_after);
        checks++;
        if (lat !== WS + 1 || busy1 !== 1'b1 || ack_after !== 1'b0) begin
            errors++;
            $display("FAIL %s_timing: lat=%0d busy=%b ack_next=%b, want lat=%0d busy=1 ack_next=0",
                     name, lat, busy1, ack_after, WS + 1);
        end
        checks++;
        if (err !== (rd && wr)) begin
            errors++;
            $display("FAIL %s_err: got %b want %b", name, err, rd && wr);
        end
        if (rd && !wr) exp = ref_mem[a];
        else exp = last_rd;
        checks++;
        if (rdat !== exp) begin
            errors++;
            $display("FAIL %s_data @%h: got %h want %h", name, a, rdat, exp);
        end
        if (wr && !rd) begin
            ref_mem[a] = d; ref_valid[a] = 1'b1;
        end
        last_rd = exp;
    endtask

    task automatic test_write_read();
        model_access("wr_123", 1'b0, 1'b1, 12'h123, 16'hBEEF);
        model_access("rd_123", 1'b1, 1'b0, 12'h123, 16'h0000);
        checks++;
        if (last_rd !== 16'hBEEF) begin
            errors++;
            $display("FAIL beef_read: got %h want BEEF", last_rd);
        end
    endtask

    task automatic test_malformed();
        model_access("wr_321", 1'b0, 1'b1, 12'h321, 16'h2222);
        model_access("bad_321", 1'b1, 1'b1, 12'h321, 16'h1111);
        model_access("rd_321", 1'b1, 1'b0, 12'h321, 16'h0000);
        checks++;
        if (last_rd !== 16'h2222) begin
            errors++;
            $display("FAIL bad_no_write: got %h want 2222", last_rd);
        end
    endtask

    task automatic test_busy_ignore();
        int acks;
        model_access("wr_777", 1'b0, 1'b1, 12'h777, 16'h7777 ^ 16'($urandom));
        model_access("wr_222", 1'b0, 1'b1, 12'h222, 16'h2222 ^ 16'($urandom));
        acks = 0;
        bus.Rd = 1'b1; bus.Wr = 1'b0; bus.Addr = 12'h777;
        for (int i = 1; i <= 2 * WS + 5; i++) begin
            @(negedge Clk);
            if (i == 1) bus.Addr = 12'h222;
            if (bus.Ack) begin
                acks++;
                checks++;
                if (i != WS + 2 && i != 2 * WS + 5) begin
                    errors++;
                    $display("FAIL held_ack_pos: ack at cycle %0d, want %0d or %0d",
                             i, WS + 2, 2 * WS + 5);
                end
                checks++;
                if (bus.RdData !== ref_mem[(i == WS + 2) ? 12'h777 : 12'h222]) begin
                    errors++;
                    $display("FAIL held_data cycle %0d: got %h want %h", i, bus.RdData,
                             ref_mem[(i == WS + 2) ? 12'h777 : 12'h222]);
                end
            end
        end
        bus.Rd = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (acks !== 2 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL held_ack_count: acks=%0d busy=%b, want 2 and 0", acks, bus.Busy);
        end
        last_rd = ref_mem[12'h222];
    endtask

    task automatic test_reset_mid_write();
        int acks;
        model_access("wr_020", 1'b0, 1'b1, 12'h020, 16'h0BAD);
        acks = 0;
        bus.Wr = 1'b1; bus.Addr = 12'h020; bus.WrData = 16'hDEAD;
        @(negedge Clk);
        bus.Wr = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < WS + 4; i++) begin
            @(negedge Clk);
            if (bus.Ack) acks++;
        end
        checks++;
        if (acks !== 0 || bus.RdData !== 16'h0) begin
            errors++;
            $display("FAIL abort_ack: acks=%0d rd=%h, want 0 and 0000", acks, bus.RdData);
        end
        last_rd = 16'h0;
        model_access("rd_020", 1'b1, 1'b0, 12'h020, 16'h0);
    endtask

    task automatic test_boundary();
        int lat; bit err, busy1, ack_after; logic [15:0] rdat;
        model_access("wr_000", 1'b0, 1'b1, 12'h000, 16'hAAAA);
        model_access("wr_fff", 1'b0, 1'b1, 12'hFFF, 16'h5555);
        model_access("rd_000", 1'b1, 1'b0, 12'h000, 16'h0);
        model_access("rd_fff", 1'b1, 1'b0, 12'hFFF, 16'h0);
        access(1'b1, 1'b0, 1'b1, 12'h000, 16'hAAAA, lat, err, rdat, busy1, ack_after);
        access(1'b1, 1'b0, 1'b1, 12'hFFF, 16'h5555, lat, err, rdat, busy1, ack_after);
        access(1'b1, 1'b1, 1'b0, 12'h000, 16'h0, lat, err, rdat, busy1, ack_after);
        checks++;
        if (lat !== 1 || rdat !== 16'hAAAA || err !== 1'b0 || ack_after !== 1'b0) begin
            errors++;
            $display("FAIL ws0_rd_000: lat=%0d rd=%h err=%b ack_next=%b, want 1 AAAA 0 0",
                     lat, rdat, err, ack_after);
        end
        access(1'b1, 1'b1, 1'b0, 12'hFFF, 16'h0, lat, err, rdat, busy1, ack_after);
        checks++;
        if (lat !== 1 || rdat !== 16'h5555 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL ws0_rd_fff: lat=%0d rd=%h busy=%b, want 1 5555 1", lat, rdat, busy1);
        end
    endtask

    task automatic test_random();
        logic [11:0] a;
        int kind;
        for (int i = 0; i < 40; i++) begin
            a = 12'($urandom);
            kind = int'($urandom_range(0, 9));
            if (kind < 4 || !ref_valid[a]) model_access("rnd_wr", 1'b0, 1'b1, a, 16'($urandom));
            else if (kind < 9) model_access("rnd_rd", 1'b1, 1'b0, a, 16'($urandom));
            else model_access("rnd_bad", 1'b1, 1'b1, a, 16'($urandom));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 4096; i++) begin
            ref_valid[i] = 1'b0;
            ref_mem[i]   = 16'h0;
        end
        test_reset();
        test_write_read();
        test_malformed();
        test_busy_ignore();
        test_reset_mid_write();
        test_boundary();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mu0_mem_responder.md
# mu0_mem_responder

Memory-side responder for the MU0 processor bus. It sits at the far end of the 12-bit address path driven by the datapath address multiplexer. It accepts one read or write request at a time and holds a 4096 x 16-bit word store. It inserts a programmable number of wait states and returns a single-cycle acknowledge with read data, so the control FSM can be exercised against slow memory.

## Interface
Parameters:
- WAIT_STATES, default 2: extra wait cycles per access; legal range 0..15.
- ADDR_W, default 12: address width; the store has 2^ADDR_W words.
- DATA_W, default 16: data word width.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Addr  input  ADDR_W  word address from the address multiplexer.
- WrData  input  DATA_W  write data.
- Rd  input  1  read request; level, sampled only in IDLE.
- Wr  input  1  write request; level, sampled only in IDLE.
- RdData  output  DATA_W  registered read data; valid while Ack=1, held otherwise.
- Ack  output  1  access complete; high for exactly one cycle per accepted request.
- Err  output  1  high together with Ack when the request was malformed (Rd and Wr both high).
- Busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - If Rd|Wr is high at the edge, latch Addr, WrData and the op (READ, WRITE or BAD if both are high).
  - Load the wait counter with WAIT_STATES and go to WAIT.
  - Otherwise remain in IDLE.
- WAIT:
  - If the counter is 0, go to RESP.
  - Otherwise decrement the counter and stay in WAIT.
  - Rd, Wr, Addr and WrData are ignored; only the latched copies are used.
- Transition WAIT->RESP performs the access on that edge:
  - READ: RdData <= mem[latched Addr].
  - WRITE: mem[latched Addr] <= latched WrData; RdData unchanged.
  - BAD: no memory change; RdData unchanged; Err registered high.
- RESP: Ack=1 (and Err=1 if BAD) for this one cycle, then unconditionally return to IDLE. Ack and Err are decoded from the state and latched op, so they are glitch-free registered values.
- The store is not reset. Its contents survive Reset and are undefined at power-up.
- Address arithmetic is pure indexing: all 2^ADDR_W addresses are distinct, with no wrap or alias.
- Reset priority: Reset=1 at an edge forces IDLE, clears the counter, Ack=0, Err=0, Busy=0, RdData=0, and aborts any in-flight access. A write in WAIT is discarded and the store is untouched.
- A request in IDLE with Reset=1 on the same edge is dropped.

## Timing
- Request accepted at edge k (state IDLE, Rd|Wr=1).
- Busy=1 from edge k through the RESP cycle.
- WAIT occupies WAIT_STATES+1 cycles. The access happens at edge k+WAIT_STATES+1.
- Ack=1 during the cycle after edge k+WAIT_STATES+1 (latency WAIT_STATES+1 cycles from accept).
- Return to IDLE at edge k+WAIT_STATES+2. The earliest next accept is edge k+WAIT_STATES+3, so the access period is WAIT_STATES+3 cycles.
- With WAIT_STATES=0, Ack is high in the second cycle after accept.
- Held requests: if Rd/Wr stay high through an access, the next access is re-accepted at the first IDLE edge. Each accept produces exactly one Ack.
- Outputs after Reset deasserts: Busy=0, Ack=0, Err=0, RdData=16'h0000 until the first completed read.

## Test plan
- Reset: Reset=1 for 2 cycles with Rd=1 -> Busy=0, Ack=0, Err=0, RdData=16'h0000; no access occurs while Reset=1.
- Write then read (WAIT_STATES=2):
  - Stimulus: Wr at 12'h123 with data 16'hBEEF, then Rd at 12'h123.
  - Required: each Ack is high exactly 3 cycles after its accept edge and lasts 1 cycle; the read returns RdData=16'hBEEF.
- Malformed request:
  - Stimulus: write 16'h2222 to 12'h321, then Rd=Wr=1 at 12'h321 with WrData 16'h1111.
  - Required: Ack=1 and Err=1 in the same cycle; RdData unchanged; a following read of 12'h321 returns 16'h2222 with Err=0.
- Busy ignore:
  - Stimulus: Rd held high at 12'h777 while Addr changes to 12'h222 during WAIT.
  - Required: the returned data is mem[12'h777]; exactly one Ack per WAIT_STATES+3-cycle period.
- Reset mid-write:
  - Stimulus: mem[12'h020]=16'h0BAD; Wr at 12'h020 with data 16'hDEAD; Reset pulsed during WAIT.
  - Required: no Ack; a later read of 12'h020 returns 16'h0BAD.
- Boundary addresses:
  - Stimulus: write 16'hAAAA to 12'h000 and 16'h5555 to 12'hFFF.
  - Required: reads return 16'hAAAA and 16'h5555 respectively (no aliasing). Repeat with WAIT_STATES=0 and check Ack in the second cycle after accept.
